// File: rtl/ntt_pkg.sv
// ntt_pkg: shared coefficient width, default modulus and ID-width helper for the NTT datapath
package ntt_pkg;
  localparam int COEFF_W = 30;
  localparam logic [COEFF_W-1:0] Q_DEFAULT = 30'd998244353;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/modular_subtractor.sv
// modular_subtractor: two-stage (a-b) mod Q, unreset datapath
module modular_subtractor
  import ntt_pkg::*;
#(
  parameter logic [COEFF_W-1:0] Q = Q_DEFAULT
) (
  input  logic               clk,
  input  logic [COEFF_W-1:0] a,
  input  logic [COEFF_W-1:0] b,
  output logic [COEFF_W-1:0] c
);
  logic [COEFF_W:0] diff_d, diff_q;
  logic [COEFF_W-1:0] c_d, c_q;
  always_comb begin
    diff_d = {1'b0, a} - {1'b0, b};
    c_d = diff_q[COEFF_W] ? diff_q[COEFF_W-1:0] + Q : diff_q[COEFF_W-1:0];
  end
  always_ff @(posedge clk) begin
    diff_q <= diff_d;
    c_q <= c_d;
  end
  assign c = c_q;
endmodule

// File: rtl/rr_grant.sv
// rr_grant: combinational round-robin pick of the first valid index at or after ptr
module rr_grant
  import ntt_pkg::*;
#(
  parameter int N = 4,
  localparam int IDW = clog2_min1(N)
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx
);
  logic [N-1:0] rot;
  logic [IDW-1:0] off;
  logic [IDW:0] sum;
  assign rot = N'({valid, valid} >> ptr);
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) off = IDW'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    grant_idx = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : sum[IDW-1:0];
    grant = |valid ? N'(1) << grant_idx : '0;
  end
endmodule

// File: rtl/modsub_rr_arbiter.sv
// modsub_rr_arbiter: round-robin sharing of one modular_subtractor with a tagged response bus
// Optional MODSUB_ARB_STATS_EN adds saturating grant/conflict counters.
module modsub_rr_arbiter
  import ntt_pkg::*;
#(
  parameter logic [COEFF_W-1:0] Q = Q_DEFAULT,
  parameter int N_REQ = 4,
  localparam int IDW = clog2_min1(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [COEFF_W*N_REQ-1:0]   req_a,
  input  logic [COEFF_W*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  output logic [IDW-1:0]             rsp_id,
  output logic [COEFF_W-1:0]         rsp_c,
  output logic                       busy
`ifdef MODSUB_ARB_STATS_EN
  ,
  output logic [31:0]                stat_grants,
  output logic [31:0]                stat_conflicts
`endif
);
  logic [N_REQ-1:0] grant;
  logic [IDW-1:0] g_idx, ptr_d, ptr_q, s1_id_d, s1_id_q, s2_id_d, s2_id_q;
  logic s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q, gnt;
  logic [COEFF_W-1:0] op_a, op_b;
  rr_grant #(.N(N_REQ)) u_grant (.valid(req_valid), .ptr(ptr_q), .grant(grant), .grant_idx(g_idx));
  modular_subtractor #(.Q(Q)) u_sub (.clk(clk), .a(op_a), .b(op_b), .c(rsp_c));
  assign gnt = |grant & ~rst;
  assign req_ready = rst ? '0 : grant;
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < N_REQ; i++)
      if (req_ready[i]) begin
        op_a = req_a[COEFF_W*i +: COEFF_W];
        op_b = req_b[COEFF_W*i +: COEFF_W];
      end
  end
  always_comb begin
    ptr_d = gnt ? ((g_idx == IDW'(N_REQ - 1)) ? '0 : g_idx + IDW'(1)) : ptr_q;
    s1_valid_d = gnt;
    s1_id_d = g_idx;
    s2_valid_d = s1_valid_q;
    s2_id_d = s1_id_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q <= s2_id_d;
    end
  end
  // Masked during reset so an op caught in the final stage never surfaces.
  assign rsp_valid = s2_valid_q & ~rst;
  assign rsp_id = s2_id_q;
  assign busy = s1_valid_q | s2_valid_q;
`ifdef MODSUB_ARB_STATS_EN
  logic [31:0] stat_grants_d, stat_grants_q, stat_conflicts_d, stat_conflicts_q;
  always_comb begin
    stat_grants_d = (gnt && stat_grants_q != '1) ? stat_grants_q + 32'd1 : stat_grants_q;
    stat_conflicts_d = ($countones(req_valid) > 1 && stat_conflicts_q != '1) ? stat_conflicts_q + 32'd1 : stat_conflicts_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants_q <= '0;
      stat_conflicts_q <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_conflicts_q <= stat_conflicts_d;
    end
  end
  assign stat_grants = stat_grants_q;
  assign stat_conflicts = stat_conflicts_q;
`endif
endmodule
